// File: rtl/pisa_pkg.sv
// Shared types and constants for the memory arbiter.
package pisa_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 4;

  // Access-size encodings shared by core and debug ports
  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    CORE      = 2'd0,
    DBG_ISSUE = 2'd1,
    DBG_RESP  = 2'd2,
    RESYNC    = 2'd3
  } arb_state_t;

  // Debug request captured on the grant cycle
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] size;
  } dbg_req_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Stall and grant counters for the arbiter; both wrap and clear on rst.
module arb_perf_counters
  import pisa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        grant_inc,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_dbg_grants
);

  // Free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_dbg_grants   <= '0;
    end else begin
      if (stall_inc) perf_stall_cycles <= perf_stall_cycles + 32'(1);
      if (grant_inc) perf_dbg_grants   <= perf_dbg_grants + 16'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between a stepping core and a debug/loader
// requester. Debug accesses steal the bus for ISSUE/RESP, then a RESYNC
// cycle lets mem_rdata return to a core address before the core steps.
// Optional: define ARBITER_PERF_EN to add perf_stall_cycles/perf_dbg_grants.
module mem_arbiter
  import pisa_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_req,
  output logic              core_enable_step,
  input  logic [ADDR_W-1:0] core_address,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_write_enable,
  input  logic [SIZE_W-1:0] core_data_size,
  output logic [DATA_W-1:0] core_data_in,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_address,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [SIZE_W-1:0] dbg_size,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [SIZE_W-1:0] mem_size,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [15:0]       perf_dbg_grants
`endif
);

  arb_state_t             state;
  arb_state_t             state_nxt;
  dbg_req_t               dbg_req_q;
  logic [CNT_W-1:0]       starve_cnt;
  logic                   starved_c;
  logic                   grant_c;

  // Grant decision: debug may take the bus only between core accesses
  always_comb begin
    starved_c = (starve_cnt == CNT_W'(STARVE_LIMIT)) && step_req;
    grant_c   = !rst
             && ((state == CORE) || (state == RESYNC))
             && dbg_valid
             && !core_write_enable
             && !starved_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CORE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      CORE:      state_nxt = grant_c ? DBG_ISSUE : CORE;
      DBG_ISSUE: state_nxt = DBG_RESP;
      DBG_RESP:  state_nxt = RESYNC;
      RESYNC:    state_nxt = grant_c ? DBG_ISSUE : CORE;
      default:   state_nxt = CORE;
    endcase
  end

  // Memory-port mux, handshake and step enable
  always_comb begin
    mem_address      = core_address;
    mem_wdata        = core_data_out;
    mem_we           = core_write_enable;
    mem_size         = core_data_size;
    core_data_in     = mem_rdata;
    dbg_ready        = grant_c;
    core_enable_step = step_req && (state == CORE) && !grant_c;
    case (state)
      DBG_ISSUE: begin
        mem_address = dbg_req_q.address;
        mem_wdata   = dbg_req_q.wdata;
        mem_we      = dbg_req_q.write;
        mem_size    = dbg_req_q.size;
      end
      DBG_RESP: begin
        mem_address = dbg_req_q.address;
        mem_wdata   = dbg_req_q.wdata;
        mem_we      = 1'b0;
        mem_size    = dbg_req_q.size;
      end
      default: ;
    endcase
  end

  // Capture the debug request fields only on the grant cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_req_q <= '0;
    end else if (grant_c) begin
      dbg_req_q.write   <= dbg_write;
      dbg_req_q.address <= dbg_address;
      dbg_req_q.wdata   <= dbg_wdata;
      dbg_req_q.size    <= dbg_size;
    end
  end

  // Read-data capture and completion pulse; reset aborts without a pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= (state == DBG_RESP);
      if ((state == DBG_RESP) && !dbg_req_q.write) dbg_rdata <= mem_rdata;
    end
  end

  // Consecutive-grant counter; any core step clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (core_enable_step) begin
      starve_cnt <= '0;
    end else if (grant_c && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

`ifdef ARBITER_PERF_EN
  arb_perf_counters u_perf (
    .clk               (clk),
    .rst               (rst),
    .stall_inc         (step_req && !core_enable_step),
    .grant_inc         (grant_c),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dbg_grants   (perf_dbg_grants)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (STARVE_LIMIT=2) with a 1-cycle memory model.
module tb_mem_arbiter;
  import pisa_pkg::*;

  logic        clk;
  logic        rst;
  logic        step_req;
  logic        core_enable_step;
  logic [31:0] core_address;
  logic [31:0] core_data_out;
  logic        core_write_enable;
  logic [1:0]  core_data_size;
  logic [31:0] core_data_in;
  logic        dbg_valid;
  logic        dbg_ready;
  logic        dbg_write;
  logic [31:0] dbg_address;
  logic [31:0] dbg_wdata;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
`ifdef ARBITER_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_dbg_grants;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_q [0:1023];

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .step_req          (step_req),
    .core_enable_step  (core_enable_step),
    .core_address      (core_address),
    .core_data_out     (core_data_out),
    .core_write_enable (core_write_enable),
    .core_data_size    (core_data_size),
    .core_data_in      (core_data_in),
    .dbg_valid         (dbg_valid),
    .dbg_ready         (dbg_ready),
    .dbg_write         (dbg_write),
    .dbg_address       (dbg_address),
    .dbg_wdata         (dbg_wdata),
    .dbg_size          (dbg_size),
    .dbg_rdata         (dbg_rdata),
    .dbg_rvalid        (dbg_rvalid),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_size          (mem_size),
    .mem_rdata         (mem_rdata)
`ifdef ARBITER_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dbg_grants   (perf_dbg_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears one cycle after the address
  always @(posedge clk) begin
    if (mem_we) mem_q[mem_address[11:2]] <= mem_wdata;
    mem_rdata <= mem_q[mem_address[11:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge where outputs are sampled
  task automatic settle();
    #4;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_q[i] = 32'h0;
    mem_q[64] = 32'hDEADBEEF;
    mem_rdata = 32'h0;

    rst = 1'b1; step_req = 1'b1;
    core_address = 32'h40; core_data_out = 32'h0; core_write_enable = 1'b0;
    core_data_size = SIZE_WORD;
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_address = 32'h100;
    dbg_wdata = 32'h0; dbg_size = SIZE_WORD;

    // Reset state
    cyc(); cyc(); settle();
    check_eq("rst_ready",  32'(dbg_ready),  32'h0);
    check_eq("rst_rvalid", 32'(dbg_rvalid), 32'h0);
    check_eq("rst_rdata",  dbg_rdata,       32'h0);
`ifdef ARBITER_PERF_EN
    check_eq("rst_perf_grants", 32'(perf_dbg_grants), 32'h0);
`endif
    cyc(); rst = 1'b0; dbg_valid = 1'b0; settle();
    check_eq("idle_step",  32'(core_enable_step), 32'h1);
    check_eq("idle_addr",  mem_address,           32'h40);
    check_eq("idle_size",  32'(mem_size),         32'(SIZE_WORD));

    // Debug read with core idle: grant T, rvalid T+3
    cyc(); step_req = 1'b0; settle();
    cyc(); dbg_valid = 1'b1; dbg_write = 1'b0; dbg_address = 32'h100; settle();
    check_eq("rd_T_ready", 32'(dbg_ready),        32'h1);
    check_eq("rd_T_step",  32'(core_enable_step), 32'h0);
    cyc(); dbg_valid = 1'b0; dbg_address = 32'h0; settle();
    check_eq("rd_T1_ready", 32'(dbg_ready),  32'h0);
    check_eq("rd_T1_addr",  mem_address,     32'h100);
    check_eq("rd_T1_we",    32'(mem_we),     32'h0);
    check_eq("rd_T1_rv",    32'(dbg_rvalid), 32'h0);
    cyc(); settle();
    check_eq("rd_T2_addr",  mem_address,     32'h100);
    check_eq("rd_T2_rv",    32'(dbg_rvalid), 32'h0);
    check_eq("rd_T2_step",  32'(core_enable_step), 32'h0);
    cyc(); settle();
    check_eq("rd_T3_rv",    32'(dbg_rvalid), 32'h1);
    check_eq("rd_T3_data",  dbg_rdata,       32'hDEADBEEF);
    check_eq("rd_T3_step",  32'(core_enable_step), 32'h0);
    cyc(); settle();
    check_eq("rd_T4_rv",    32'(dbg_rvalid), 32'h0);

    // Debug byte write while the core wants to step
    cyc(); step_req = 1'b1; settle();
    cyc();
    dbg_valid = 1'b1; dbg_write = 1'b1; dbg_address = 32'h20;
    dbg_wdata = 32'h55; dbg_size = SIZE_BYTE;
    settle();
    check_eq("wr_T_ready", 32'(dbg_ready),        32'h1);
    check_eq("wr_T_step",  32'(core_enable_step), 32'h0);
    check_eq("wr_T_we",    32'(mem_we),           32'h0);
    cyc(); dbg_valid = 1'b0; dbg_write = 1'b0; dbg_wdata = 32'h0; dbg_size = SIZE_WORD; settle();
    check_eq("wr_T1_we",   32'(mem_we),    32'h1);
    check_eq("wr_T1_addr", mem_address,    32'h20);
    check_eq("wr_T1_data", mem_wdata,      32'h55);
    check_eq("wr_T1_size", 32'(mem_size),  32'(SIZE_BYTE));
    check_eq("wr_T1_step", 32'(core_enable_step), 32'h0);
    cyc(); settle();
    check_eq("wr_T2_we",   32'(mem_we),           32'h0);
    check_eq("wr_T2_step", 32'(core_enable_step), 32'h0);
    cyc(); settle();
    check_eq("wr_T3_rv",   32'(dbg_rvalid),       32'h1);
    check_eq("wr_T3_hold", dbg_rdata,             32'hDEADBEEF);
    check_eq("wr_T3_step", 32'(core_enable_step), 32'h0);
    check_eq("wr_T3_addr", mem_address,           32'h40);
    cyc(); settle();
    check_eq("wr_T4_step", 32'(core_enable_step), 32'h1);
    check_eq("wr_mem",     mem_q[8],              32'h55);

    // Starvation with limit 2: grants at 0,3 then a step at 7, repeating
    for (int c = 0; c < 17; c++) begin
      cyc();
      if (c == 0) begin
        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_address = 32'h100;
      end
      settle();
      check_eq($sformatf("starve_ready_c%0d", c), 32'(dbg_ready),
               32'((c == 0) || (c == 3) || (c == 8) || (c == 11) || (c == 16)));
      check_eq($sformatf("starve_step_c%0d", c), 32'(core_enable_step),
               32'((c == 7) || (c == 15)));
      check_eq($sformatf("starve_rv_c%0d", c), 32'(dbg_rvalid),
               32'((c == 3) || (c == 6) || (c == 11) || (c == 14)));
    end
    cyc(); dbg_valid = 1'b0;
    repeat (5) cyc();

    // Core write collides with a debug request
    step_req = 1'b0;
    core_write_enable = 1'b1; core_address = 32'h80; core_data_out = 32'h1234;
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_address = 32'h100;
    settle();
    check_eq("col_A_ready", 32'(dbg_ready), 32'h0);
    check_eq("col_A_we",    32'(mem_we),    32'h1);
    check_eq("col_A_addr",  mem_address,    32'h80);
    check_eq("col_A_data",  mem_wdata,      32'h1234);
    cyc(); core_write_enable = 1'b0; core_address = 32'h40; settle();
    check_eq("col_B_ready", 32'(dbg_ready), 32'h1);
    check_eq("col_B_we",    32'(mem_we),    32'h0);
    cyc(); dbg_valid = 1'b0; settle();
    check_eq("col_C_addr",  mem_address,    32'h100);
    cyc(); cyc(); settle();
    check_eq("col_rv",      32'(dbg_rvalid), 32'h1);
    check_eq("col_rdata",   dbg_rdata,       32'hDEADBEEF);
    check_eq("col_mem",     mem_q[32],       32'h1234);
    repeat (3) cyc();

    // Reset while in DBG_ISSUE aborts the access
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_address = 32'h20;
    settle();
    check_eq("rm_G_ready", 32'(dbg_ready), 32'h1);
    cyc(); dbg_valid = 1'b0; rst = 1'b1; settle();
    check_eq("rm_G1_addr", mem_address, 32'h20);
    cyc();
    rst = 1'b0; step_req = 1'b1; core_write_enable = 1'b1;
    core_address = 32'h44; core_data_out = 32'h0;
    settle();
    check_eq("rm_G2_rv",    32'(dbg_rvalid),       32'h0);
    check_eq("rm_G2_step",  32'(core_enable_step), 32'h1);
    check_eq("rm_G2_we",    32'(mem_we),           32'h1);
    check_eq("rm_G2_addr",  mem_address,           32'h44);
    check_eq("rm_G2_rdata", dbg_rdata,             32'h0);
`ifdef ARBITER_PERF_EN
    check_eq("rm_perf_stall",  perf_stall_cycles,     32'h0);
    check_eq("rm_perf_grants", 32'(perf_dbg_grants),  32'h0);
`endif
    cyc(); core_write_enable = 1'b0; settle();
    check_eq("rm_G3_rv",    32'(dbg_rvalid), 32'h0);
    check_eq("rm_G3_we",    32'(mem_we),     32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, which sets the maximum number of consecutive debug grants while core steps are pending (legal range 1..15).
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- step_req  in  1  external request to advance the core one step per cycle.
- core_enable_step  out  1  step enable to the core.
- core_address  in  32  core bus address.
- core_data_out  in  32  core write data.
- core_write_enable  in  1  core write strobe.
- core_data_size  in  2  core access size.
- core_data_in  out  32  read data to the core.
- dbg_valid  in  1  debug/loader request valid.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_write  in  1  debug request is a write.
- dbg_address  in  32  debug address.
- dbg_wdata  in  32  debug write data.
- dbg_size  in  2  debug access size.
- dbg_rdata  out  32  debug read data.
- dbg_rvalid  out  1  one-cycle completion pulse.
- mem_address  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_size  out  2  memory access size.
- mem_rdata  in  32  memory read data, valid 1 cycle after its address.

Function
REQ-003 The FSM SHALL have states CORE, DBG_ISSUE, DBG_RESP and RESYNC.
REQ-004 In CORE and RESYNC, mem_* SHALL be combinational pass-through of core_*; in DBG_ISSUE and DBG_RESP, mem_* SHALL be driven from the registered debug request.
REQ-005 core_data_in SHALL equal mem_rdata at all times.
REQ-006 core_enable_step SHALL equal step_req AND state==CORE AND no grant in the current cycle.
REQ-007 Grant conditions:
- state is CORE or RESYNC;
- dbg_valid=1;
- core_write_enable=0;
- NOT (starve_cnt==STARVE_LIMIT AND step_req=1).
REQ-008 On a grant, dbg_ready SHALL be 1 for exactly that cycle, the dbg_* fields SHALL be registered, and the next state SHALL be DBG_ISSUE.
REQ-009 Without a grant, CORE SHALL remain in CORE and RESYNC SHALL go to CORE.
REQ-010 DBG_ISSUE SHALL drive mem_we=registered dbg_write for one cycle, then go to DBG_RESP.
REQ-011 DBG_RESP SHALL set mem_we=0 and go to RESYNC; on a read it SHALL capture mem_rdata into dbg_rdata, and on a write dbg_rdata SHALL hold its value.
REQ-012 dbg_rvalid SHALL pulse high for exactly the one cycle after DBG_RESP, for both reads and writes.
REQ-013 Latency SHALL be: grant at cycle T, completion pulse (dbg_rvalid) at T+3; the earliest core step after a single debug access SHALL be T+4.
REQ-014 starve_cnt (4 bit) SHALL increment on each grant, saturating at STARVE_LIMIT, and SHALL clear on any cycle with core_enable_step=1.
REQ-015 When step_req=0, debug grants SHALL be unlimited; starve_cnt still counts but does not block.
REQ-016 dbg_valid deasserted before acceptance SHALL cancel the request with no side effects; the dbg_* fields SHALL be sampled only on the grant cycle.
REQ-017 The core SHALL never step while mem_rdata reflects a debug address; the RESYNC state guarantees this.

Reset
REQ-018 On rst, the block SHALL enter state CORE with starve_cnt=0, dbg_rdata=0, dbg_rvalid=0 and dbg_ready=0.
REQ-019 rst during DBG_ISSUE or DBG_RESP SHALL abort the transaction with no dbg_rvalid pulse; mem_we SHALL follow core_write_enable from the next cycle.

Configuration
REQ-020 With ARBITER_PERF_EN defined, the block SHALL add outputs perf_stall_cycles (32 bit, counts cycles with step_req=1 and core_enable_step=0) and perf_dbg_grants (16 bit, counts grants); both SHALL wrap, clear on rst, and the ports SHALL be absent when the macro is undefined.

Structure
REQ-021 Package pisa_pkg SHALL hold arb_state_t (2-bit enum) and the data-size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01 and SIZE_WORD=2'b10.
REQ-022 The performance counters SHALL live in sub-module arb_perf_counters, instantiated only under ARBITER_PERF_EN.

Verification
REQ-023 Debug read: step_req=0, dbg read at 0x100, memory holds 0xDEADBEEF -> dbg_ready at T, dbg_rvalid at T+3, dbg_rdata=0xDEADBEEF, core_enable_step=0 throughout.
REQ-024 Debug write while core runs: step_req=1, dbg write 0x55 to 0x20, size SIZE_BYTE -> mem_we=1 only at T+1 with mem_address=0x20, core_enable_step=0 for T..T+3 and 1 at T+4.
REQ-025 Starvation: STARVE_LIMIT=2, step_req=1, dbg_valid held high -> two grants, then exactly one core step, then a grant again; pattern repeats.
REQ-026 Core write collision: core_write_enable=1 in the same cycle as dbg_valid rises -> no grant that cycle, mem_we follows the core, grant on the next eligible cycle.
REQ-027 Reset mid-transaction: rst in DBG_ISSUE -> no dbg_rvalid, state=CORE; with ARBITER_PERF_EN, both counters=0.
